// File: rtl/dbus_arbiter.sv
// Round-robin arbiter sharing one DATA_BUS slave port between NUM_MASTERS requesters.
// Optional response watchdog enabled by defining DBUS_ARB_TIMEOUT_EN.
module dbus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_MASTERS-1:0]    m_req,
  input  logic [NUM_MASTERS*32-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [NUM_MASTERS*4-1:0]  m_be,
  input  logic [NUM_MASTERS*32-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  output logic [NUM_MASTERS-1:0]    m_err,
  output logic [31:0]               m_rdata,
  output logic                      s_req,
  output logic [31:0]               s_addr,
  output logic                      s_we,
  output logic [3:0]                s_be,
  output logic [31:0]               s_wdata,
  input  logic                      s_gnt,
  input  logic                      s_rvalid,
  input  logic                      s_err,
  input  logic [31:0]               s_rdata
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   rr_ptr_r;
  logic [IW-1:0]   owner_r;
  logic [IW-1:0]   sel_s;
  logic [IW-1:0]   act_s;
  logic            any_req_s;
  logic            timeout_s;
  logic [NUM_MASTERS-1:0] sel_oh_s;
  logic [NUM_MASTERS-1:0] own_oh_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (int'(i) >= NUM_MASTERS - 1) begin
      return {IW{1'b0}};
    end else begin
      return IW'(int'(i) + 1);
    end
  endfunction

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_MASTERS-1:0] v;
    v = {NUM_MASTERS{1'b0}};
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (int'(i) == k) begin
        v[k] = 1'b1;
      end else begin
        v[k] = 1'b0;
      end
    end
    return v;
  endfunction

  // Round-robin pick: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    int j;
    logic found;
    found = 1'b0;
    sel_s = rr_ptr_r;
    j     = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      j = int'(rr_ptr_r) + k;
      if (j >= NUM_MASTERS) begin
        j = j - NUM_MASTERS;
      end else begin
        j = j;
      end
      if (!found && m_req[j]) begin
        found = 1'b1;
        sel_s = IW'(j);
      end else begin
        found = found;
      end
    end
    any_req_s = found;
  end

  assign act_s    = (state_r == IDLE) ? sel_s : owner_r;
  assign sel_oh_s = onehot(sel_s);
  assign own_oh_s = onehot(owner_r);

`ifdef DBUS_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;
  assign timeout_s = (state_r == WAIT_RVALID) && (tmo_cnt_r == 16'(TIMEOUT_CYCLES));

  // Watchdog counts WAIT_RVALID cycles that pass without a response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_r != WAIT_RVALID) begin
      tmo_cnt_r <= 16'd0;
    end else if (!s_rvalid && !timeout_s) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Arbitration FSM: owner is locked from request through response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rr_ptr_r <= {IW{1'b0}};
      owner_r  <= {IW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= sel_s;
            if (s_gnt) begin
              rr_ptr_r <= next_idx(sel_s);
              state_r  <= WAIT_RVALID;
            end else begin
              state_r  <= WAIT_GNT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_GNT: begin
          if (!m_req[owner_r]) begin
            state_r <= IDLE;
          end else if (s_gnt) begin
            rr_ptr_r <= next_idx(owner_r);
            state_r  <= WAIT_RVALID;
          end else begin
            state_r <= WAIT_GNT;
          end
        end
        WAIT_RVALID: begin
          // A response arriving on the timeout cycle wins; both end the transaction.
          if (s_rvalid || timeout_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_RVALID;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency request mux toward the slave and response demux toward the owner.
  always_comb begin
    s_req    = 1'b0;
    s_addr   = 32'h0;
    s_we     = 1'b0;
    s_be     = 4'h0;
    s_wdata  = 32'h0;
    m_gnt    = {NUM_MASTERS{1'b0}};
    m_rvalid = {NUM_MASTERS{1'b0}};
    m_err    = {NUM_MASTERS{1'b0}};
    m_rdata  = s_rdata;
    case (state_r)
      IDLE, WAIT_GNT: begin
        if ((state_r == IDLE) ? any_req_s : m_req[owner_r]) begin
          s_req   = 1'b1;
          s_addr  = m_addr[act_s*32 +: 32];
          s_we    = m_we[act_s];
          s_be    = m_be[act_s*4 +: 4];
          s_wdata = m_wdata[act_s*32 +: 32];
          m_gnt   = ((state_r == IDLE) ? sel_oh_s : own_oh_s) & {NUM_MASTERS{s_gnt}};
        end else begin
          s_req = 1'b0;
        end
      end
      WAIT_RVALID: begin
        if (s_rvalid) begin
          m_rvalid = own_oh_s;
          m_err    = own_oh_s & {NUM_MASTERS{s_err}};
        end else if (timeout_s) begin
          m_rvalid = own_oh_s;
          m_err    = own_oh_s;
          m_rdata  = 32'h0;
        end else begin
          m_rvalid = {NUM_MASTERS{1'b0}};
        end
      end
      default: begin
        s_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter (2 masters); responses checked through a scoreboard queue.
module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [63:0] m_addr;
  logic [1:0]  m_we;
  logic [7:0]  m_be;
  logic [63:0] m_wdata;
  logic [1:0]  m_gnt, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic        s_req, s_we;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_gnt, s_rvalid, s_err;
  logic [31:0] s_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]  rv;
    logic [1:0]  err;
    logic [31:0] rdata;
  } resp_t;
  resp_t sb_q[$];

  dbus_arbiter #(.NUM_MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_err(s_err), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] rv, input logic [1:0] err, input logic [31:0] rd);
    resp_t r;
    r.rv = rv; r.err = err; r.rdata = rd;
    sb_q.push_back(r);
  endtask

  task automatic check_resp(input string tag);
    resp_t r;
    if (m_rvalid !== 2'b00) begin
      if (sb_q.size() == 0) begin
        chk({tag, "_unexpected_rvalid"}, {30'd0, m_rvalid}, 32'd0);
      end else begin
        r = sb_q.pop_front();
        chk({tag, "_rvalid"}, {30'd0, m_rvalid}, {30'd0, r.rv});
        chk({tag, "_err"},    {30'd0, m_err},    {30'd0, r.err});
        chk({tag, "_rdata"},  m_rdata,           r.rdata);
      end
    end else begin
      chk({tag, "_rvalid_missing"}, {31'd0, sb_q.size() == 0}, 32'd1);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0; m_req = 2'b00; m_addr = 64'h0; m_we = 2'b00; m_be = 8'h0; m_wdata = 64'h0;
    s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = 32'h0;
    m_addr[31:0] = 32'h0000_1000; m_addr[63:32] = 32'h0000_2000;
    m_wdata[31:0] = 32'h1111_1111; m_wdata[63:32] = 32'hDEAD_BEEF;
    m_be = 8'hFF;
    repeat (3) cyc();
    settle();
    chk("rst_gnt", {30'd0, m_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, m_rvalid}, 32'd0);
    chk("rst_sreq", {31'd0, s_req}, 32'd0);
    chk("rst_saddr", s_addr, 32'd0);

    // Single master read, grant same cycle, rvalid next cycle
    cyc(); rst_n = 1'b1; m_req = 2'b01; s_gnt = 1'b1; settle();
    chk("single_gnt", {30'd0, m_gnt}, 32'd1);
    chk("single_saddr", s_addr, 32'h0000_1000);
    chk("single_swe", {31'd0, s_we}, 32'd0);
    cyc(); m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
    push(2'b01, 2'b00, 32'hCAFE_F00D); settle();
    check_resp("single");
    chk("single_gnt_in_rsp", {30'd0, m_gnt}, 32'd0);

    // Contention with gnt always high: rr_ptr is 1 after master0's grant
    cyc(); s_rvalid = 1'b0; m_req = 2'b11; s_gnt = 1'b1;
    exp_g = 2'b10;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("cont_gnt", {30'd0, m_gnt}, {30'd0, exp_g});
      chk("cont_saddr", s_addr, exp_g[1] ? 32'h0000_2000 : 32'h0000_1000);
      cyc(); s_rvalid = 1'b1; s_rdata = 32'hA000_0000 + 32'(i);
      push(exp_g, 2'b00, 32'hA000_0000 + 32'(i)); settle();
      check_resp("cont");
      chk("cont_gnt_ignored", {30'd0, m_gnt}, 32'd0);
      cyc(); s_rvalid = 1'b0;
      exp_g = ~exp_g;
    end
    m_req = 2'b00; s_gnt = 1'b0;

    // Locking: master0 owns while slave stalls and master1 also requests
    cyc(); m_req = 2'b01; settle();
    chk("lock_first_gnt", {30'd0, m_gnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(); m_req = 2'b11; settle();
      chk("lock_saddr", s_addr, 32'h0000_1000);
      chk("lock_gnt", {30'd0, m_gnt}, 32'd0);
    end
    cyc(); s_gnt = 1'b1; settle();
    chk("lock_gnt_owner", {30'd0, m_gnt}, 32'd1);
    cyc(); s_gnt = 1'b0; m_req = 2'b10; s_rvalid = 1'b1; s_rdata = 32'h0000_0055;
    push(2'b01, 2'b00, 32'h0000_0055); settle();
    check_resp("lock");
    chk("lock_m1_blocked", {30'd0, m_gnt}, 32'd0);

    // Error response on master1 write
    cyc(); s_rvalid = 1'b0; m_we = 2'b10; m_be[7:4] = 4'b0011; s_gnt = 1'b1; settle();
    chk("err_gnt", {30'd0, m_gnt}, 32'd2);
    chk("err_swe", {31'd0, s_we}, 32'd1);
    chk("err_sbe", {28'd0, s_be}, 32'h3);
    chk("err_swdata", s_wdata, 32'hDEAD_BEEF);
    cyc(); m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_err = 1'b1; s_rdata = 32'h0;
    push(2'b10, 2'b10, 32'h0); settle();
    check_resp("err");
    cyc(); s_rvalid = 1'b0; s_err = 1'b0; m_we = 2'b00;

    // Owner drops request before grant: back to IDLE without grant
    m_req = 2'b10; settle();
    chk("drop_gnt", {30'd0, m_gnt}, 32'd0);
    cyc(); m_req = 2'b00; s_gnt = 1'b1; settle();
    chk("drop_sreq", {31'd0, s_req}, 32'd0);
    chk("drop_nogrant", {30'd0, m_gnt}, 32'd0);
    cyc(); s_gnt = 1'b0;

    // Stray rvalid in IDLE is ignored
    s_rvalid = 1'b1; settle();
    chk("idle_rvalid_ignored", {30'd0, m_rvalid}, 32'd0);

    // Reset during WAIT_RVALID: late rvalid dropped, rr_ptr back to 0
    cyc(); s_rvalid = 1'b0; m_req = 2'b01; s_gnt = 1'b1; settle();
    chk("rst_mid_gnt", {30'd0, m_gnt}, 32'd1);
    cyc(); m_req = 2'b00; s_gnt = 1'b0; rst_n = 1'b0;
    cyc(); rst_n = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1234_5678; settle();
    chk("rst_mid_no_rvalid", {30'd0, m_rvalid}, 32'd0);
    cyc(); s_rvalid = 1'b0; m_req = 2'b11; s_gnt = 1'b1; settle();
    chk("rst_mid_rrptr0", {30'd0, m_gnt}, 32'd1);
    cyc(); m_req = 2'b00; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D;
    push(2'b01, 2'b00, 32'h0BAD_F00D); settle();
    check_resp("rst_mid_after");
    cyc(); s_rvalid = 1'b0;

`ifdef DBUS_ARB_TIMEOUT_EN
    // Timeout: master1 granted, no response; forced error at count 4
    m_req = 2'b10; s_gnt = 1'b1; s_rdata = 32'hFFFF_FFFF; settle();
    chk("tmo_gnt", {30'd0, m_gnt}, 32'd2);
    cyc(); m_req = 2'b00; s_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("tmo_quiet", {30'd0, m_rvalid}, 32'd0);
      cyc();
    end
    push(2'b10, 2'b10, 32'h0); settle();
    check_resp("tmo");
    cyc(); s_rvalid = 1'b1; settle();
    chk("tmo_late_ignored", {30'd0, m_rvalid}, 32'd0);
    cyc(); s_rvalid = 1'b0;
`endif

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
